a2d_rr_sched: RTL

- Round-robin conversion scheduler for the 8-channel 12-bit SPI A2D (ADC128S-style).
- Sequences the two-transaction A2D protocol: the channel address is sent in transaction 1, and the result is returned in transaction 2.
- Maintains one result register per sensor: left load cell, right load cell, steering pot, battery.
- Sits between the balance/steer control logic and the A2D pins. Contains its own 16-bit SPI master.

---
 rtl/a2d_pkg.sv | 20 ++
 rtl/a2d_rr_sched_spi_mstr16.sv | 81 ++++++++
 rtl/a2d_rr_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the round-robin A2D conversion scheduler.
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, XFER1, GAP, XFER2, STORE} sched_state_t;
    typedef enum logic [1:0] {LFT, RGHT, STEER, BATT} sensor_t;

    // Total SS_n-high clocks between the two transactions of a conversion.
    localparam int          GAP_CLKS = 2;
    localparam logic [10:0] CMD_PAD  = 11'h000;

    function automatic sensor_t next_sensor(input sensor_t s);
        case (s)
            LFT:     return RGHT;
            RGHT:    return STEER;
            STEER:   return BATT;
            default: return LFT;
        endcase
    endfunction

endpackage

// File: rtl/a2d_rr_sched_spi_mstr16.sv
// 16-bit SPI master (mode 3 style): SCLK idles high, MOSI changes on falls, MISO sampled on rises.
module spi_mstr16 #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int         HALF      = SCLK_DIV / 2;
    localparam int         DW        = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [5:0] LAST_HALF = 6'd33;

    // Frame = 34 half-periods: front porch, 16 x (low, high), back porch.
    logic          active_q;
    logic [DW-1:0] div_q;
    logic [5:0]    half_q;
    logic [5:0]    half_inc;
    logic [15:0]   shft_q;
    logic          ss_n_q, sclk_q, mosi_q, done_q;

    assign half_inc = half_q + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            shft_q   <= '0;
            ss_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (wrt) begin
                    active_q <= 1'b1;
                    ss_n_q   <= 1'b0;
                    div_q    <= '0;
                    half_q   <= '0;
                    shft_q   <= cmd;
                    mosi_q   <= cmd[15];
                end
            end else if (div_q == DW'(HALF - 1)) begin
                div_q <= '0;
                if (half_q == LAST_HALF) begin
                    active_q <= 1'b0;
                    ss_n_q   <= 1'b1;
                    done_q   <= 1'b1;
                end else begin
                    half_q <= half_inc;
                    if (half_inc[0]) begin
                        // Odd halves are SCLK low, except the back porch; first fall keeps cmd[15].
                        if (half_inc != LAST_HALF) sclk_q <= 1'b0;
                        if (half_inc != 6'd1 && half_inc != LAST_HALF) mosi_q <= shft_q[15];
                    end else begin
                        sclk_q <= 1'b1;
                        shft_q <= {shft_q[14:0], MISO};
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign done    = done_q;
    assign rd_data = shft_q;
    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin scheduler for an 8-channel 12-bit SPI A2D; two transactions per conversion.
// Define A2D_AUTO_EN to free-run conversions back to back (nxt ignored).
module a2d_rr_sched
    import a2d_pkg::*;
#(
    parameter int         SCLK_DIV = 32,
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        vld
);

    sched_state_t state_q;
    sensor_t      ptr_q;
    logic [1:0]   gap_q;
    logic         busy_q, vld_q;
    logic [11:0]  lft_q, rght_q, steer_q, batt_q;

    logic [2:0]   ch;
    logic [15:0]  cmd, rd_data;
    logic         start, wrt, done;
    logic [3:0]   unused_hi;

`ifdef A2D_AUTO_EN
    logic unused_nxt;
    assign unused_nxt = nxt;
    assign start      = 1'b1;
`else
    assign start      = nxt;
`endif

    always_comb begin
        ch = CH_LFT;
        case (ptr_q)
            RGHT:    ch = CH_RGHT;
            STEER:   ch = CH_STEER;
            BATT:    ch = CH_BATT;
            default: ch = CH_LFT;
        endcase
    end

    assign cmd       = {2'b00, ch, CMD_PAD};
    assign unused_hi = rd_data[15:12];

    // wrt is decoded from state so SS_n falls on the very next edge; one GAP cycle plus the done cycle gives GAP_CLKS.
    assign wrt = ((state_q == IDLE) && start) ||
                 ((state_q == GAP) && (gap_q == 2'(GAP_CLKS - 2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= LFT;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            lft_q   <= '0;
            rght_q  <= '0;
            steer_q <= '0;
            batt_q  <= '0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    busy_q  <= 1'b1;
                    state_q <= XFER1;
                end
                XFER1: if (done) begin
                    gap_q   <= '0;
                    state_q <= GAP;
                end
                GAP: if (wrt) state_q <= XFER2;
                     else     gap_q   <= gap_q + 2'd1;
                XFER2: if (done) state_q <= STORE;
                STORE: begin
                    case (ptr_q)
                        LFT:     lft_q   <= rd_data[11:0];
                        RGHT:    rght_q  <= rd_data[11:0];
                        STEER:   steer_q <= rd_data[11:0];
                        default: batt_q  <= rd_data[11:0];
                    endcase
                    vld_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    ptr_q   <= next_sensor(ptr_q);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt    (wrt),
        .cmd    (cmd),
        .done   (done),
        .rd_data(rd_data),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;
    assign busy      = busy_q;
    assign vld       = vld_q;

endmodule
